fixed_point_addsub_pipe: RTL and testbench

Pipelined, parametrised fixed-point add/subtract unit with valid/ready flow control, per-transaction signed-overflow detection, optional saturation, and a sticky overflow event counter. Sits in the `fixed_point` arithmetic library and serves the vertex/raster datapaths that need add and subtract throughput of one operation per cycle under backpressure.

---
 rtl/fixed_point_addsub_pipe.sv | 130 +++++++++++++
 tb/tb_fixed_point_addsub_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_addsub_pipe.sv
// Pipelined signed add/subtract with valid/ready flow, overflow flag and a saturating overflow counter.
// Define FIXED_POINT_SAT_EN to build in the per-transaction saturation mux.
module fixed_point_addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int FRAC   = 16,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             ovf_clear
);

   // FRAC only documents the binary point; the arithmetic does not depend on it.
   localparam int FRAC_UNUSED = FRAC;

   logic              adv;
   logic [STAGES-1:0] vld;
   logic [WIDTH-1:0]  a_s;
   logic [WIDTH-1:0]  b_s;
   logic              sub_s;
   logic              sat_s;
   logic [WIDTH-1:0]  sum;
   logic              ovf_n;
   logic [WIDTH-1:0]  res_n;

   assign adv       = !out_valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else if (adv) begin
         vld[0] <= in_valid;
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   // Operands ride through STAGES-1 registers; the last stage computes and holds the result.
   generate
      if (STAGES == 1) begin : g_direct
         assign a_s   = op1;
         assign b_s   = op2;
         assign sub_s = sub;
         assign sat_s = sat;
      end else begin : g_opnd
         logic [WIDTH-1:0] a_q   [STAGES-1];
         logic [WIDTH-1:0] b_q   [STAGES-1];
         logic             sub_q [STAGES-1];
         logic             sat_q [STAGES-1];

         always_ff @(posedge clk) begin
            if (adv) begin
               a_q[0]   <= op1;
               b_q[0]   <= op2;
               sub_q[0] <= sub;
               sat_q[0] <= sat;
               for (int i = 1; i < STAGES-1; i++) begin
                  a_q[i]   <= a_q[i-1];
                  b_q[i]   <= b_q[i-1];
                  sub_q[i] <= sub_q[i-1];
                  sat_q[i] <= sat_q[i-1];
               end
            end
         end

         assign a_s   = a_q[STAGES-2];
         assign b_s   = b_q[STAGES-2];
         assign sub_s = sub_q[STAGES-2];
         assign sat_s = sat_q[STAGES-2];
      end
   endgenerate

   always_comb begin
      sum   = a_s + (sub_s ? ~b_s : b_s) + {{(WIDTH-1){1'b0}}, sub_s};
      ovf_n = 1'b0;
      if (sub_s) begin
         ovf_n = (a_s[WIDTH-1] != b_s[WIDTH-1]) & (sum[WIDTH-1] == b_s[WIDTH-1]);
      end else begin
         ovf_n = (a_s[WIDTH-1] == b_s[WIDTH-1]) & (sum[WIDTH-1] != a_s[WIDTH-1]);
      end
   end

`ifdef FIXED_POINT_SAT_EN
   always_comb begin
      res_n = sum;
      if (sat_s && ovf_n) begin
         res_n = a_s[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   logic sat_unused;
   assign sat_unused = sat_s;
   assign res_n      = sum;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         result   <= '0;
         overflow <= 1'b0;
      end else if (adv) begin
         result   <= res_n;
         overflow <= ovf_n;
      end
   end

   // Clear wins over a coincident overflow handshake; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset || ovf_clear) begin
         ovf_count <= '0;
      end else if (out_valid && out_ready && overflow && (ovf_count != {CNT_W{1'b1}})) begin
         ovf_count <= ovf_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Directed bench for fixed_point_addsub_pipe (WIDTH=16, STAGES=3, CNT_W=4); honours FIXED_POINT_SAT_EN.
module tb_fixed_point_addsub_pipe;

   localparam int WIDTH  = 16;
   localparam int STAGES = 3;
   localparam int CNT_W  = 4;
`ifdef FIXED_POINT_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic [CNT_W-1:0] ovf_count;
   logic             ovf_clear;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fixed_point_addsub_pipe #(
      .WIDTH (WIDTH),
      .FRAC  (8),
      .STAGES(STAGES),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op1      (op1),
      .op2      (op2),
      .sub      (sub),
      .sat      (sat),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .overflow (overflow),
      .ovf_count(ovf_count),
      .ovf_clear(ovf_clear)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference built from the mathematically exact sum, not from sign bits.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 input logic st, output logic [15:0] r, output logic o);
      int ai;
      int bi;
      int t;
      ai = int'($signed(a));
      bi = int'($signed(b));
      t  = s ? ai - bi : ai + bi;
      o  = (t > 32767) || (t < -32768);
      r  = t[15:0];
      if (SAT_ON && st && o) r = (t > 0) ? 16'h7FFF : 16'h8000;
   endfunction

   // Sends one transaction into an idle pipe; returns at #1 after the edge where out_valid rises.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic st,
                        output logic [15:0] r, output logic o, output int lat);
      op1 = a; op2 = b; sub = s; sat = st;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result;
      o = overflow;
   endtask

   initial begin
      logic [15:0] r;
      logic        o;
      int          lat;
      int          cnt_model;
      logic [16:0] q[$];
      logic [16:0] e;
      logic [15:0] mr;
      logic        mo;
      logic [15:0] held;
      bit          have_held;
      bit          acc;
      int          sent;
      int          got;
      int          cyc;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
      op1 = '0; op2 = '0; sub = 1'b0; sat = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_ovf_count", ovf_count, 0);
      reset = 1'b0;

      do_op(16'h7000, 16'h2000, 1'b0, 1'b1, r, o, lat);
      chk("add_pos_ovf_res", r, SAT_ON ? 16'h7FFF : 16'h9000);
      chk("add_pos_ovf_flag", o, 1);
      chk("latency", lat, STAGES);

      do_op(16'h8000, 16'h0001, 1'b1, 1'b1, r, o, lat);
      chk("sub_neg_ovf_res", r, SAT_ON ? 16'h8000 : 16'h7FFF);
      chk("sub_neg_ovf_flag", o, 1);

      do_op(16'h0000, 16'h8000, 1'b1, 1'b1, r, o, lat);
      chk("sub_min_ovf_res", r, SAT_ON ? 16'h7FFF : 16'h8000);
      chk("sub_min_ovf_flag", o, 1);

      do_op(16'h0005, 16'h0003, 1'b1, 1'b0, r, o, lat);
      chk("sub_small_res", r, 16'h0002);
      chk("sub_small_flag", o, 0);

      do_op(16'h1234, 16'h0001, 1'b0, 1'b0, r, o, lat);
      chk("add_small_res", r, 16'h1235);
      chk("add_small_flag", o, 0);

      do_op(16'h8000, 16'h8000, 1'b0, 1'b1, r, o, lat);
      chk("add_neg_ovf_res", r, SAT_ON ? 16'h8000 : 16'h0000);
      chk("add_neg_ovf_flag", o, 1);

      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, r, o, lat);
      chk("add_carry_res", r, 16'h0000);
      chk("add_carry_flag", o, 0);
      chk("latency_last", lat, STAGES);

      @(posedge clk); #1;
      chk("ovf_count_4", ovf_count, 4);
      cnt_model = 4;

      // Random stream with a 5-cycle output stall in the middle.
      sent = 0; got = 0; cyc = 0; have_held = 1'b0;
      op1 = 16'($urandom); op2 = 16'($urandom); sub = 1'($urandom); sat = 1'($urandom);
      in_valid = 1'b1; out_ready = 1'b1;
      while (got < 20 && cyc < 200) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("stream_extra_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("stream_result", result, e[15:0]);
               chk("stream_overflow", overflow, e[16]);
               if (e[16] && cnt_model < 15) cnt_model++;
            end
            got++;
         end
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            if (!have_held) begin
               have_held = 1'b1;
               held = result;
            end else begin
               chk("stall_hold", result, held);
            end
         end
         acc = in_valid && in_ready;
         if (acc) begin
            model(op1, op2, sub, sat, mr, mo);
            q.push_back({mo, mr});
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         out_ready = !(cyc >= 8 && cyc < 13);
         if (acc) begin
            if (sent < 20) begin
               op1 = 16'($urandom); op2 = 16'($urandom); sub = 1'($urandom); sat = 1'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("stream_delivered", got, 20);
      chk("stream_stall_seen", have_held, 1);
      chk("stream_ovf_count", ovf_count, cnt_model);

      // Reset with two transactions in flight.
      out_ready = 1'b1;
      op1 = 16'h0001; op2 = 16'h0002; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      op1 = 16'h7FFF; op2 = 16'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_ovf_count", ovf_count, 0);
      chk("midrst_result", result, 0);
      chk("midrst_in_ready", in_ready, 1);
      repeat (STAGES + 1) begin
         @(posedge clk); #1;
         chk("midrst_no_ghost", out_valid, 0);
      end
      do_op(16'h0005, 16'h0003, 1'b0, 1'b0, r, o, lat);
      chk("post_rst_res", r, 16'h0008);
      chk("post_rst_flag", o, 0);
      chk("post_rst_latency", lat, STAGES);

      // Counter saturation at 15 after 17 overflowing results.
      @(posedge clk); #1;
      op1 = 16'h7000; op2 = 16'h2000; sub = 1'b0; sat = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (17) @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (STAGES + 3) @(posedge clk);
      #1;
      chk("cnt_saturate", ovf_count, 15);

      // Clear coincident with an overflowing handshake.
      do_op(16'h7000, 16'h2000, 1'b0, 1'b0, r, o, lat);
      chk("clr_pre_flag", o, 1);
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      chk("cnt_clear_priority", ovf_count, 0);

      // Overflowing result held under backpressure is counted only once accepted.
      op1 = 16'h8000; op2 = 16'h0001; sub = 1'b1; sat = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (STAGES + 2) @(posedge clk);
      #1;
      chk("held_out_valid", out_valid, 1);
      chk("held_in_ready", in_ready, 0);
      chk("held_result", result, 16'h7FFF);
      chk("held_not_counted", ovf_count, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("held_counted", ovf_count, 1);
      chk("held_drained", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
